// File: rtl/blink_pkg.sv
// Shared rate codes, decoder FSM states and blink-generator default toggle counts.
// Latency: none (definitions only). Backpressure: none.
package blink_pkg;

    typedef logic [2:0] rate_code_t;

    localparam rate_code_t RATE_NONE = 3'd0;
    localparam rate_code_t RATE_1HZ  = 3'd1;
    localparam rate_code_t RATE_2HZ  = 3'd2;
    localparam rate_code_t RATE_3HZ  = 3'd3;
    localparam rate_code_t RATE_5HZ  = 3'd4;
    localparam rate_code_t RATE_10HZ = 3'd5;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam int DEF_CLKS_1HZ  = 25000000;
    localparam int DEF_CLKS_2HZ  = 12500000;
    localparam int DEF_CLKS_3HZ  = 8333333;
    localparam int DEF_CLKS_5HZ  = 5000000;
    localparam int DEF_CLKS_10HZ = 2500000;

    // A generator toggling after CLKS counts produces a half-period of CLKS+1 clocks.
    function automatic int win_lo(input int clks, input int tol_shift);
        return (clks + 1) - ((clks + 1) >> tol_shift);
    endfunction

    function automatic int win_hi(input int clks, input int tol_shift);
        return (clks + 1) + ((clks + 1) >> tol_shift);
    endfunction

endpackage

// File: rtl/blink_rate_decoder_if.sv
// Measurement result bundle from the blink rate decoder to its consumer.
// Latency: none (wiring only). Backpressure: none, results are pulses/levels.
interface blink_rate_decoder_if
    import blink_pkg::*;
#(
    parameter int CNT_W = 26
);
    logic             o_valid;
    logic [CNT_W-1:0] o_half_period;
    rate_code_t       o_rate_code;
    logic             o_locked;
    logic             o_timeout;

    modport master (
        output o_valid,
        output o_half_period,
        output o_rate_code,
        output o_locked,
        output o_timeout
    );

    modport slave (
        input o_valid,
        input o_half_period,
        input o_rate_code,
        input o_locked,
        input o_timeout
    );
endinterface

// File: rtl/blink_sync_edge.sv
// Synchronizes the async blink input and emits a one-cycle pulse on either polarity of change.
// Latency: edge high 2 clocks after input change (+DEGLITCH_CLKS with BLINK_DEGLITCH_EN). Backpressure: none.
module blink_sync_edge #(
    parameter int DEGLITCH_CLKS = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_blink,
    output logic o_edge
);

    if (DEGLITCH_CLKS < 1) begin : g_bad_deglitch
        $error("DEGLITCH_CLKS must be at least 1");
    end

    logic s1, s2, s3;
    logic lvl;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_blink;
            s2 <= s1;
            s3 <= lvl;
        end
    end

`ifdef BLINK_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH_CLKS + 1);

    logic            filt;
    logic [DG_W-1:0] dg_cnt;

    // The filtered level follows s2 only after DEGLITCH_CLKS consecutive disagreeing cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            filt   <= 1'b0;
            dg_cnt <= '0;
        end else if (s2 != filt) begin
            if (dg_cnt == DG_W'(DEGLITCH_CLKS - 1)) begin
                filt   <= s2;
                dg_cnt <= '0;
            end else begin
                dg_cnt <= dg_cnt + 1'b1;
            end
        end else begin
            dg_cnt <= '0;
        end
    end

    assign lvl = filt;
`else
    assign lvl = s2;
`endif

    assign o_edge = lvl ^ s3;

endmodule

// File: rtl/blink_rate_decoder.sv
// Measures blink half-periods, classifies them into 1/2/3/5/10 Hz and reports lock and loss-of-signal.
// Latency: o_valid 3 clocks after a blink transition (+DEGLITCH_CLKS with BLINK_DEGLITCH_EN). Backpressure: none.
module blink_rate_decoder
    import blink_pkg::*;
#(
    parameter int CLKS_1HZ      = DEF_CLKS_1HZ,
    parameter int CLKS_2HZ      = DEF_CLKS_2HZ,
    parameter int CLKS_3HZ      = DEF_CLKS_3HZ,
    parameter int CLKS_5HZ      = DEF_CLKS_5HZ,
    parameter int CLKS_10HZ     = DEF_CLKS_10HZ,
    parameter int TOL_SHIFT     = 3,
    parameter int TIMEOUT       = 40000000,
    parameter int CNT_W         = 26,
    parameter int DEGLITCH_CLKS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_blink,
    blink_rate_decoder_if.master bus
);

    if (TIMEOUT >= (2 ** CNT_W)) begin : g_bad_timeout
        $error("CNT_W too narrow to hold TIMEOUT");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [CNT_W-1:0] LO_1HZ  = CNT_W'(win_lo(CLKS_1HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI_1HZ  = CNT_W'(win_hi(CLKS_1HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] LO_2HZ  = CNT_W'(win_lo(CLKS_2HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI_2HZ  = CNT_W'(win_hi(CLKS_2HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] LO_3HZ  = CNT_W'(win_lo(CLKS_3HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI_3HZ  = CNT_W'(win_hi(CLKS_3HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] LO_5HZ  = CNT_W'(win_lo(CLKS_5HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI_5HZ  = CNT_W'(win_hi(CLKS_5HZ,  TOL_SHIFT));
    localparam logic [CNT_W-1:0] LO_10HZ = CNT_W'(win_lo(CLKS_10HZ, TOL_SHIFT));
    localparam logic [CNT_W-1:0] HI_10HZ = CNT_W'(win_hi(CLKS_10HZ, TOL_SHIFT));

    logic             blink_edge;
    logic [CNT_W-1:0] cnt;
    state_t           state, state_nxt;
    logic             meas_done;
    logic             sig_lost;
    rate_code_t       class_code;

    blink_sync_edge #(
        .DEGLITCH_CLKS(DEGLITCH_CLKS)
    ) u_sync_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_blink(i_blink),
        .o_edge (blink_edge)
    );

    // Counts clocks since the last edge; saturates so loss-of-signal stays detectable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (blink_edge) begin
            cnt <= CNT_W'(1);
        end else if (cnt != TIMEOUT_C) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout beats a coincident edge; that edge still restarts the count as a first edge.
    always_comb begin
        state_nxt = state;
        meas_done = 1'b0;
        sig_lost  = 1'b0;
        case (state)
            IDLE: begin
                if (blink_edge) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (cnt == TIMEOUT_C) begin
                    sig_lost  = 1'b1;
                    state_nxt = blink_edge ? MEASURE : IDLE;
                end else if (blink_edge) begin
                    meas_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lowest code wins if windows were ever configured to overlap.
    always_comb begin
        class_code = RATE_NONE;
        if (cnt >= LO_1HZ && cnt <= HI_1HZ) begin
            class_code = RATE_1HZ;
        end else if (cnt >= LO_2HZ && cnt <= HI_2HZ) begin
            class_code = RATE_2HZ;
        end else if (cnt >= LO_3HZ && cnt <= HI_3HZ) begin
            class_code = RATE_3HZ;
        end else if (cnt >= LO_5HZ && cnt <= HI_5HZ) begin
            class_code = RATE_5HZ;
        end else if (cnt >= LO_10HZ && cnt <= HI_10HZ) begin
            class_code = RATE_10HZ;
        end
    end

    // The registered rate code doubles as the previous-code memory for lock detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_valid       <= 1'b0;
            bus.o_timeout     <= 1'b0;
            bus.o_half_period <= '0;
            bus.o_rate_code   <= RATE_NONE;
            bus.o_locked      <= 1'b0;
        end else begin
            bus.o_valid   <= meas_done;
            bus.o_timeout <= sig_lost;
            if (sig_lost) begin
                bus.o_rate_code <= RATE_NONE;
                bus.o_locked    <= 1'b0;
            end else if (meas_done) begin
                bus.o_half_period <= cnt;
                bus.o_rate_code   <= class_code;
                bus.o_locked      <= (class_code != RATE_NONE) && (class_code == bus.o_rate_code);
            end
        end
    end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed bench for blink_rate_decoder with small sim periods; honours BLINK_DEGLITCH_EN.
module tb_blink_rate_decoder;
    import blink_pkg::*;

`ifdef BLINK_DEGLITCH_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int cyc;
        int hp;
        int code;
        int lk;
    } vrec_t;

    logic clk;
    logic rst;
    logic blink;
    int   cyc;
    int   n_tests;
    int   n_fail;

    vrec_t vq[$];
    int    toq[$];
    int    tq[$];

    blink_rate_decoder_if #(.CNT_W(26)) bus ();

    blink_rate_decoder #(
        .CLKS_1HZ     (99),
        .CLKS_2HZ     (49),
        .CLKS_3HZ     (32),
        .CLKS_5HZ     (19),
        .CLKS_10HZ    (9),
        .TOL_SHIFT    (3),
        .TIMEOUT      (300),
        .CNT_W        (26),
        .DEGLITCH_CLKS(4)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_blink(blink),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records every o_valid / o_timeout pulse with the cycle it was seen.
    always @(posedge clk) begin
        vrec_t r;
        cyc = cyc + 1;
        #1;
        if (bus.o_valid === 1'b1) begin
            r.cyc  = cyc;
            r.hp   = int'(bus.o_half_period);
            r.code = int'(bus.o_rate_code);
            r.lk   = int'(bus.o_locked);
            vq.push_back(r);
        end
        if (bus.o_timeout === 1'b1) toq.push_back(cyc);
    end

    task automatic tog();
        @(negedge clk);
        blink = ~blink;
        tq.push_back(cyc);
    endtask

    task automatic gap(input int n);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        blink = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vq.delete();
        toq.delete();
        tq.delete();
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_tests++;
        if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.o_timeout); end
        n_tests++;
        if (bus.o_half_period !== 26'd0) begin n_fail++; $display("FAIL reset_hp: got %0d want 0", bus.o_half_period); end
        n_tests++;
        if (bus.o_rate_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", bus.o_rate_code); end
        n_tests++;
        if (bus.o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", bus.o_locked); end
    endtask

    task automatic test_rate_2hz();
        do_reset();
        tog(); gap(50); tog(); gap(50); tog(); gap(LAT + 3);
        n_tests++;
        if (vq.size() !== 2) begin n_fail++; $display("FAIL r2_count: got %0d valids want 2", vq.size()); end
        for (int i = 0; i < 2 && i < vq.size(); i++) begin
            n_tests++;
            if (vq[i].cyc !== tq[i+1] + LAT) begin n_fail++; $display("FAIL r2_latency[%0d]: got cyc %0d want %0d", i, vq[i].cyc, tq[i+1] + LAT); end
            n_tests++;
            if (vq[i].hp !== 50 || vq[i].code !== 2) begin n_fail++; $display("FAIL r2_meas[%0d]: got hp %0d code %0d want hp 50 code 2", i, vq[i].hp, vq[i].code); end
            n_tests++;
            if (vq[i].lk !== i) begin n_fail++; $display("FAIL r2_locked[%0d]: got %0d want %0d", i, vq[i].lk, i); end
        end
    endtask

    task automatic test_tolerance();
        int p[4]    = '{56, 57, 44, 43};
        int code[4] = '{2, 0, 2, 0};
        do_reset();
        tog();
        for (int i = 0; i < 4; i++) begin
            gap(p[i]); tog();
        end
        gap(LAT + 3);
        n_tests++;
        if (vq.size() !== 4) begin n_fail++; $display("FAIL tol_count: got %0d valids want 4", vq.size()); end
        for (int i = 0; i < 4 && i < vq.size(); i++) begin
            n_tests++;
            if (vq[i].hp !== p[i] || vq[i].code !== code[i] || vq[i].lk !== 0) begin
                n_fail++;
                $display("FAIL tol_meas[%0d]: got hp %0d code %0d lk %0d want hp %0d code %0d lk 0",
                         i, vq[i].hp, vq[i].code, vq[i].lk, p[i], code[i]);
            end
        end
    endtask

    task automatic test_rate_change();
        int p[4]    = '{10, 10, 100, 100};
        int code[4] = '{5, 5, 1, 1};
        int lk[4]   = '{0, 1, 0, 1};
        do_reset();
        tog();
        for (int i = 0; i < 4; i++) begin
            gap(p[i]); tog();
        end
        gap(LAT + 3);
        n_tests++;
        if (vq.size() !== 4) begin n_fail++; $display("FAIL chg_count: got %0d valids want 4", vq.size()); end
        for (int i = 0; i < 4 && i < vq.size(); i++) begin
            n_tests++;
            if (vq[i].hp !== p[i] || vq[i].code !== code[i] || vq[i].lk !== lk[i]) begin
                n_fail++;
                $display("FAIL chg_meas[%0d]: got hp %0d code %0d lk %0d want hp %0d code %0d lk %0d",
                         i, vq[i].hp, vq[i].code, vq[i].lk, p[i], code[i], lk[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int last_v;
        do_reset();
        tog(); gap(20); tog(); gap(20); tog();
        gap(310);
        n_tests++;
        if (vq.size() !== 2 || vq[vq.size()-1].lk !== 1) begin n_fail++; $display("FAIL to_prelock: got %0d valids want 2 with lock", vq.size()); end
        last_v = tq[2] + LAT;
        n_tests++;
        if (toq.size() !== 1) begin n_fail++; $display("FAIL to_count: got %0d timeout pulses want 1", toq.size()); end
        else begin
            n_tests++;
            if (toq[0] !== last_v + 300) begin n_fail++; $display("FAIL to_cycle: got cyc %0d want %0d", toq[0], last_v + 300); end
        end
        n_tests++;
        if (bus.o_rate_code !== 3'd0 || bus.o_locked !== 1'b0) begin n_fail++; $display("FAIL to_clear: got code %0d lk %b want 0 0", bus.o_rate_code, bus.o_locked); end
        n_tests++;
        if (bus.o_half_period !== 26'd20) begin n_fail++; $display("FAIL to_hp_hold: got %0d want 20", bus.o_half_period); end
        vq.delete();
        tog(); gap(30); tog(); gap(LAT + 3);
        n_tests++;
        if (vq.size() !== 1) begin n_fail++; $display("FAIL to_rearm_count: got %0d valids want 1", vq.size()); end
        else begin
            n_tests++;
            if (vq[0].cyc !== tq[4] + LAT || vq[0].hp !== 30 || vq[0].code !== 3) begin
                n_fail++;
                $display("FAIL to_rearm_meas: got cyc %0d hp %0d code %0d want cyc %0d hp 30 code 3", vq[0].cyc, vq[0].hp, vq[0].code, tq[4] + LAT);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tog(); gap(50); tog(); gap(10);
        n_tests++;
        if (bus.o_rate_code !== 3'd2) begin n_fail++; $display("FAIL ar_pre_code: got %0d want 2", bus.o_rate_code); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.o_half_period !== 26'd0 || bus.o_rate_code !== 3'd0 || bus.o_locked !== 1'b0 ||
            bus.o_valid !== 1'b0 || bus.o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_immediate: got hp %0d code %0d lk %b v %b to %b want all 0",
                     bus.o_half_period, bus.o_rate_code, bus.o_locked, bus.o_valid, bus.o_timeout);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vq.delete();
        tq.delete();
        tog(); gap(20); tog(); gap(LAT + 3);
        n_tests++;
        if (vq.size() !== 1) begin n_fail++; $display("FAIL ar_first_edge: got %0d valids want 1", vq.size()); end
        else begin
            n_tests++;
            if (vq[0].hp !== 20 || vq[0].code !== 4 || vq[0].cyc !== tq[1] + LAT) begin
                n_fail++;
                $display("FAIL ar_meas: got hp %0d code %0d cyc %0d want hp 20 code 4 cyc %0d", vq[0].hp, vq[0].code, vq[0].cyc, tq[1] + LAT);
            end
        end
    endtask

    task automatic test_glitch();
`ifdef BLINK_DEGLITCH_EN
        int n_exp = 1;
        int hp[3]   = '{50, 0, 0};
        int code[3] = '{2, 0, 0};
`else
        int n_exp = 3;
        int hp[3]   = '{50, 20, 1};
        int code[3] = '{2, 4, 0};
`endif
        do_reset();
        tog(); gap(50); tog(); gap(20); tog(); gap(1); tog(); gap(LAT + 3);
        n_tests++;
        if (vq.size() !== n_exp) begin n_fail++; $display("FAIL gl_count: got %0d valids want %0d", vq.size(), n_exp); end
        for (int i = 0; i < n_exp && i < vq.size(); i++) begin
            n_tests++;
            if (vq[i].hp !== hp[i] || vq[i].code !== code[i]) begin
                n_fail++;
                $display("FAIL gl_meas[%0d]: got hp %0d code %0d want hp %0d code %0d", i, vq[i].hp, vq[i].code, hp[i], code[i]);
            end
        end
    endtask

    initial begin
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        blink   = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_rate_2hz();
        test_tolerance();
        test_rate_change();
        test_timeout();
        test_async_reset();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_rate_decoder.md
Name: blink_rate_decoder

Overview:
- Receive-side counterpart to the design's multi-rate LED blink generators.
- Takes one asynchronous blink input (looped-back blinker output or external pin) and measures the time between its toggles.
- Classifies each half-period into one of five nominal rates (1/2/3/5/10 Hz) with a tolerance window, and reports lock and loss-of-signal.
- Used for board self-test of the blinker outputs and for decoding a rate-coded status line.

Parameters:
- CLKS_1HZ, 25000000, generator toggle-count constant; nominal half-period = CLKS_1HZ+1 clocks
- CLKS_2HZ, 12500000, same, 2 Hz
- CLKS_3HZ, 8333333, same, 3 Hz
- CLKS_5HZ, 5000000, same, 5 Hz
- CLKS_10HZ, 2500000, same, 10 Hz
- TOL_SHIFT, 3, tolerance = nominal >> TOL_SHIFT (12.5%)
- TIMEOUT, 40000000, clocks without an edge before loss-of-signal
- CNT_W, 26, counter/measurement width; must hold TIMEOUT
- DEGLITCH_CLKS, 4, stability length, used only with the optional feature

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_blink  in  1  asynchronous blink input
- o_valid  out  1  one-cycle pulse: new measurement on o_half_period/o_rate_code
- o_half_period  out  CNT_W  clocks between the last two detected edges
- o_rate_code  out  3  0=none/unknown, 1=1Hz, 2=2Hz, 3=3Hz, 4=5Hz, 5=10Hz
- o_locked  out  1  last two measurements have the same nonzero code
- o_timeout  out  1  one-cycle pulse on loss-of-signal

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - All outputs, counter and synchronizer flops go to 0; state goes to IDLE.
  - A reset mid-measurement discards the partial count.
- Input path and edge detection:
  - 2-flop synchronizer (s1, s2), then delay flop s3.
  - edge = s2 XOR s3 (both polarities count).
  - o_valid/o_timeout are registered on the clock edge where edge/timeout is high.
  - o_valid rises 3 i_clk edges after an i_blink transition that meets setup.
- Counter:
  - Set to 1 on edge; otherwise increments, saturating at TIMEOUT.
  - Edges at cycles t0 and t0+N give o_half_period = N.
- FSM, 2 states:
  - IDLE, edge: counter := 1, go to MEASURE. No o_valid; outputs hold.
  - MEASURE, edge: o_half_period := counter; o_rate_code := classify(counter); o_valid pulses; stay in MEASURE.
  - MEASURE, counter == TIMEOUT: o_timeout pulses, o_rate_code := 0, o_locked := 0, go to IDLE. o_half_period holds its last value.
  - Timeout and edge in the same cycle: timeout wins. The edge is treated as an IDLE first edge (counter := 1, state MEASURE).
- Classify:
  - nom_k = CLKS_k + 1; tol_k = nom_k >> TOL_SHIFT.
  - Code k when nom_k - tol_k <= hp <= nom_k + tol_k (inclusive); otherwise 0.
  - Comparisons are unsigned at CNT_W bits.
  - Windows must not overlap; if more than one matches, the lowest code wins.
- o_locked:
  - Updated only with o_valid or o_timeout.
  - Set when the new code is nonzero and equals the previous code.
  - Cleared on any mismatch, code 0, or timeout.
  - The previous code is cleared by reset and by timeout.
- Outputs other than the pulses hold between events.

Optional Feature:
- BLINK_DEGLITCH_EN defined:
  - s2 feeds a filter; its output changes only after s2 differs from it for DEGLITCH_CLKS consecutive cycles.
  - Edge detection uses the filter output.
  - Adds DEGLITCH_CLKS cycles of latency; steady-state half-periods are unchanged.
  - Pulses shorter than DEGLITCH_CLKS are ignored.
- Undefined: edge detection uses s2 directly; DEGLITCH_CLKS is unused.

Decomposition:
- blink_pkg holds:
  - rate code constants RATE_NONE..RATE_10HZ
  - FSM state enum {IDLE, MEASURE}
  - default CLKS_* values, shared with the blink generators
- Sub-module blink_sync_edge:
  - synchronizer, optional deglitch filter, edge detector
  - output: single-cycle edge
- Top module holds the counter, FSM, classifier and lock logic.

Test Plan:
- Sim params for all tests: CLKS_1HZ=99, CLKS_2HZ=49, CLKS_3HZ=32, CLKS_5HZ=19, CLKS_10HZ=9, TOL_SHIFT=3, TIMEOUT=300. This gives nominals 100/50/33/20/10 and tolerances 12/6/4/2/1.
- Toggle every 50 clocks, 3 edges:
  - no o_valid on edge 1
  - o_valid on edges 2 and 3, each 3 clocks after the transition
  - o_half_period=50, o_rate_code=2
  - o_locked=1 after edge 3
- Toggle every 56, then every 57:
  - 56 -> code 2
  - 57 -> code 0 and o_locked=0
  - repeat at 44 -> 2 and 43 -> 0
- Toggle every 10 for 3 edges, then every 100:
  - code 5 with locked=1
  - then code 1 with locked=0
  - then code 1 with locked=1
- Stop toggling after locked at 20:
  - o_timeout pulses exactly 300 clocks after the last detected edge
  - code=0, locked=0
  - next edge gives no o_valid; the following edge does
- Assert i_rst between clock edges mid-measurement:
  - all outputs 0 immediately
  - after release, the first edge produces no o_valid
- 1-clock glitch on i_blink:
  - with BLINK_DEGLITCH_EN: no o_valid
  - without: o_valid with o_half_period=1, code 0
